// File: rtl/sdram_cmd_decoder.sv
// Passive SDRAM command-bus decoder: bank/row tracking, mode capture, data-window model, sticky errors.
// Latency: decode/state 1 cycle after sample edge, rd_valid CL cycles after READ; backpressure: none (observer).
module sdram_cmd_decoder #(
    parameter int ROW_W = 12,
    parameter int TRCD  = 3,
    parameter int TRP   = 3,
    parameter int TRFC  = 7
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 CS_N,
    input  logic                 RAS_N,
    input  logic                 CAS_N,
    input  logic                 WE_N,
    input  logic [1:0]           BA,
    input  logic [ROW_W-1:0]     SA,
    output logic [2:0]           cmd_code,
    output logic [3:0]           bank_open,
    output logic [4*ROW_W-1:0]   open_row,
    output logic [1:0]           cas_lat,
    output logic [3:0]           burst_len,
    output logic                 rd_valid,
    output logic                 wr_active,
    output logic [5:0]           err
);

    localparam logic [2:0] C_NOP = 3'd0;
    localparam logic [2:0] C_ACT = 3'd1;
    localparam logic [2:0] C_RD  = 3'd2;
    localparam logic [2:0] C_WR  = 3'd3;
    localparam logic [2:0] C_BST = 3'd4;
    localparam logic [2:0] C_PRE = 3'd5;
    localparam logic [2:0] C_REF = 3'd6;
    localparam logic [2:0] C_LMR = 3'd7;

    localparam int TMAX = (TRCD > TRP) ? ((TRCD > TRFC) ? TRCD : TRFC)
                                       : ((TRP > TRFC) ? TRP : TRFC);
    localparam int CW = $clog2(TMAX + 1);
    localparam logic [CW-1:0] TRCD_LD = CW'(TRCD - 1);
    localparam logic [CW-1:0] TRP_LD  = CW'(TRP - 1);
    localparam logic [CW-1:0] TRFC_LD = CW'(TRFC - 1);

    logic [2:0]       dec;
    logic [5:0]       err_set;
    logic             mode_ok;
    logic [CW-1:0]    trcd_cnt [4];
    logic [CW-1:0]    trp_cnt  [4];
    logic [CW-1:0]    trfc_cnt;
    logic [ROW_W-1:0] row_q    [4];
    logic [3:1]       rp_vld;
    logic [2:0]       rp_bl    [3:1];
    logic [3:1]       bp_vld;
    logic [2:0]       rd_left;
    logic [2:0]       wr_left;
    logic [3:0]       bl_full;
    logic [2:0]       bl_m1;

    always_comb begin
        dec = C_NOP;
        if (!CS_N) begin
            case ({RAS_N, CAS_N, WE_N})
                3'b011:  dec = C_ACT;
                3'b101:  dec = C_RD;
                3'b100:  dec = C_WR;
                3'b110:  dec = C_BST;
                3'b010:  dec = C_PRE;
                3'b001:  dec = C_REF;
                3'b000:  dec = C_LMR;
                default: dec = C_NOP;
            endcase
        end
    end

    // CL must be 2 or 3 (SA[5] set) and BL code 0..3 (SA[2] clear)
    assign mode_ok = SA[5] && !SA[2];
    assign bl_full = burst_len - 4'd1;
    assign bl_m1   = bl_full[2:0];
    assign open_row = {row_q[3], row_q[2], row_q[1], row_q[0]};

    always_comb begin
        err_set    = '0;
        err_set[0] = (dec == C_ACT) && bank_open[BA];
        err_set[1] = ((dec == C_RD) || (dec == C_WR)) && !bank_open[BA];
        err_set[2] = ((dec == C_RD) || (dec == C_WR)) && (trcd_cnt[BA] != '0);
        err_set[3] = (dec == C_ACT) && (trp_cnt[BA] != '0);
        err_set[4] = (((dec == C_REF) || (dec == C_LMR)) && (|bank_open))
                   || ((dec != C_NOP) && (trfc_cnt != '0));
        err_set[5] = (dec == C_LMR) && !mode_ok;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cmd_code  <= C_NOP;
            bank_open <= '0;
            cas_lat   <= 2'd2;
            burst_len <= 4'd1;
            rd_valid  <= 1'b0;
            wr_active <= 1'b0;
            err       <= '0;
            trfc_cnt  <= '0;
            rd_left   <= '0;
            wr_left   <= '0;
            rp_vld    <= '0;
            bp_vld    <= '0;
            for (int b = 0; b < 4; b++) begin
                trcd_cnt[b] <= '0;
                trp_cnt[b]  <= '0;
                row_q[b]    <= '0;
            end
            for (int i = 1; i <= 3; i++) rp_bl[i] <= '0;
        end else begin
            cmd_code <= dec;
            err      <= err | err_set;

            for (int b = 0; b < 4; b++) begin
                if (trcd_cnt[b] != '0) trcd_cnt[b] <= trcd_cnt[b] - 1'b1;
                if (trp_cnt[b]  != '0) trp_cnt[b]  <= trp_cnt[b]  - 1'b1;
            end
            if (trfc_cnt != '0) trfc_cnt <= trfc_cnt - 1'b1;

            case (dec)
                C_ACT: begin
                    bank_open[BA] <= 1'b1;
                    row_q[BA]     <= SA;
                    trcd_cnt[BA]  <= TRCD_LD;
                end
                C_PRE: begin
                    if (SA[10]) begin
                        bank_open <= '0;
                        for (int b = 0; b < 4; b++) trp_cnt[b] <= TRP_LD;
                    end else begin
                        bank_open[BA] <= 1'b0;
                        trp_cnt[BA]   <= TRP_LD;
                    end
                end
                C_REF: trfc_cnt <= TRFC_LD;
                C_LMR: begin
                    if (mode_ok) begin
                        cas_lat   <= SA[5:4];
                        burst_len <= 4'd1 << SA[1:0];
                    end
                end
                default: ;
            endcase

            // Delay lines: slot i fires i edges from now; READ and BST enter at slot CL
            rp_vld   <= {1'b0, rp_vld[3:2]};
            rp_bl[1] <= rp_bl[2];
            rp_bl[2] <= rp_bl[3];
            bp_vld   <= {1'b0, bp_vld[3:2]};
            if (dec == C_RD) begin
                if (cas_lat == 2'd3) begin
                    rp_vld[3] <= 1'b1;
                    rp_bl[3]  <= bl_m1;
                end else begin
                    rp_vld[2] <= 1'b1;
                    rp_bl[2]  <= bl_m1;
                end
            end
            if (dec == C_BST) begin
                if (cas_lat == 2'd3) bp_vld[3] <= 1'b1;
                else                 bp_vld[2] <= 1'b1;
            end
            if (dec == C_WR) rp_vld <= '0;

            if (dec == C_WR) begin
                rd_valid <= 1'b0;
                rd_left  <= '0;
            end else if (bp_vld[1]) begin
                rd_valid <= 1'b0;
                rd_left  <= '0;
            end else if (rp_vld[1]) begin
                rd_valid <= 1'b1;
                rd_left  <= rp_bl[1];
            end else if (rd_valid) begin
                if (rd_left == '0) rd_valid <= 1'b0;
                else               rd_left  <= rd_left - 1'b1;
            end

            if (dec == C_WR) begin
                wr_active <= 1'b1;
                wr_left   <= bl_m1;
            end else if ((dec == C_RD) || (dec == C_BST)) begin
                wr_active <= 1'b0;
            end else if (wr_active) begin
                if (wr_left == '0) wr_active <= 1'b0;
                else               wr_left   <= wr_left - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sdram_cmd_decoder.sv
// Randomized and directed bench for sdram_cmd_decoder against a cycle-history reference model.
module tb_sdram_cmd_decoder;

    localparam int ROW_W = 12;
    localparam int TRCD  = 3;
    localparam int TRP   = 3;
    localparam int TRFC  = 7;

    localparam logic [2:0] R_ACT = 3'b011;
    localparam logic [2:0] R_RD  = 3'b101;
    localparam logic [2:0] R_WR  = 3'b100;
    localparam logic [2:0] R_BST = 3'b110;
    localparam logic [2:0] R_PRE = 3'b010;
    localparam logic [2:0] R_REF = 3'b001;
    localparam logic [2:0] R_LMR = 3'b000;
    localparam logic [2:0] R_NOP = 3'b111;

    logic             CLK = 1'b0;
    logic             RESET;
    logic             CS_N, RAS_N, CAS_N, WE_N;
    logic [1:0]       BA;
    logic [ROW_W-1:0] SA;
    logic [2:0]       cmd_code;
    logic [3:0]       bank_open;
    logic [4*ROW_W-1:0] open_row;
    logic [1:0]       cas_lat;
    logic [3:0]       burst_len;
    logic             rd_valid;
    logic             wr_active;
    logic [5:0]       err;

    sdram_cmd_decoder #(.ROW_W(ROW_W), .TRCD(TRCD), .TRP(TRP), .TRFC(TRFC)) dut (
        .CLK(CLK), .RESET(RESET), .CS_N(CS_N), .RAS_N(RAS_N), .CAS_N(CAS_N), .WE_N(WE_N),
        .BA(BA), .SA(SA), .cmd_code(cmd_code), .bank_open(bank_open), .open_row(open_row),
        .cas_lat(cas_lat), .burst_len(burst_len), .rd_valid(rd_valid), .wr_active(wr_active),
        .err(err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Model: per-cycle command history plus architectural state
    int h_cmd [0:8191];
    int h_cl  [0:8191];
    int h_bl  [0:8191];
    int cyc, base;
    int m_cl, m_bl, m_code;
    logic [3:0]       m_open;
    logic [ROW_W-1:0] m_row [4];
    logic [5:0]       m_err;
    int last_act [4];
    int last_pre [4];
    int last_ref;

    function automatic int decode(input logic cs_n, input logic [2:0] rcw);
        if (cs_n) return 0;
        case (rcw)
            3'b011:  return 1;
            3'b101:  return 2;
            3'b100:  return 3;
            3'b110:  return 4;
            3'b010:  return 5;
            3'b001:  return 6;
            3'b000:  return 7;
            default: return 0;
        endcase
    endfunction

    // Most recent READ whose data has started owns the window, unless cut by a later WRITE or BST
    function automatic logic exp_rd(input int c);
        int r;
        r = -1;
        for (int k = c - 1; k > base && k >= c - 16; k--) begin
            if (h_cmd[k] == 2 && k + h_cl[k] <= c) begin
                r = k;
                break;
            end
        end
        if (r < 0) return 1'b0;
        if (c > r + h_cl[r] + h_bl[r] - 1) return 1'b0;
        for (int k = r + 1; k <= c; k++) begin
            if (h_cmd[k] == 3) return 1'b0;
            if (h_cmd[k] == 4 && k + h_cl[k] <= c) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic exp_wr(input int c);
        for (int k = c; k > base && k >= c - 16; k--) begin
            if (h_cmd[k] == 3) return (c <= k + h_bl[k] - 1);
            if (h_cmd[k] == 2 || h_cmd[k] == 4) return 1'b0;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        base   = cyc;
        m_open = '0;
        m_cl   = 2;
        m_bl   = 1;
        m_err  = '0;
        m_code = 0;
        last_ref = -1000;
        for (int b = 0; b < 4; b++) begin
            m_row[b]    = '0;
            last_act[b] = -1000;
            last_pre[b] = -1000;
        end
    endtask

    task automatic step(input logic cs_n, input logic [2:0] rcw, input logic [1:0] ba,
                        input logic [ROW_W-1:0] sa);
        int code;
        @(negedge CLK);
        CS_N = cs_n;
        {RAS_N, CAS_N, WE_N} = rcw;
        BA = ba;
        SA = sa;
        @(posedge CLK);
        #1;
        cyc++;
        code = decode(cs_n, rcw);
        h_cmd[cyc] = code;
        h_cl[cyc]  = m_cl;
        h_bl[cyc]  = m_bl;
        if (code != 0 && cyc - last_ref < TRFC) m_err[4] = 1'b1;
        case (code)
            1: begin
                if (m_open[ba]) m_err[0] = 1'b1;
                if (cyc - last_pre[ba] < TRP) m_err[3] = 1'b1;
                m_open[ba]   = 1'b1;
                m_row[ba]    = sa;
                last_act[ba] = cyc;
            end
            2, 3: begin
                if (!m_open[ba]) m_err[1] = 1'b1;
                if (cyc - last_act[ba] < TRCD) m_err[2] = 1'b1;
            end
            5: begin
                if (sa[10]) begin
                    m_open = '0;
                    for (int b = 0; b < 4; b++) last_pre[b] = cyc;
                end else begin
                    m_open[ba]   = 1'b0;
                    last_pre[ba] = cyc;
                end
            end
            6: begin
                if (|m_open) m_err[4] = 1'b1;
                last_ref = cyc;
            end
            7: begin
                if (|m_open) m_err[4] = 1'b1;
                if (sa[5:4] >= 2 && sa[2:0] <= 3) begin
                    m_cl = int'(sa[5:4]);
                    m_bl = 1 << sa[2:0];
                end else begin
                    m_err[5] = 1'b1;
                end
            end
            default: ;
        endcase
        m_code = code;
    endtask

    task automatic nop();
        step(1'b0, R_NOP, 2'd0, '0);
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        RESET = 1'b1;
        CS_N  = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        @(posedge CLK);
        #1;
        n_cmp++; if (cmd_code !== 3'd0) begin n_bad++; $display("FAIL reset cmd_code got=%0d want=0", cmd_code); end
        n_cmp++; if (bank_open !== 4'd0) begin n_bad++; $display("FAIL reset bank_open got=%b want=0000", bank_open); end
        n_cmp++; if (open_row !== '0) begin n_bad++; $display("FAIL reset open_row got=%h want=0", open_row); end
        n_cmp++; if (cas_lat !== 2'd2) begin n_bad++; $display("FAIL reset cas_lat got=%0d want=2", cas_lat); end
        n_cmp++; if (burst_len !== 4'd1) begin n_bad++; $display("FAIL reset burst_len got=%0d want=1", burst_len); end
        n_cmp++; if (rd_valid !== 1'b0 || wr_active !== 1'b0) begin n_bad++; $display("FAIL reset windows got=%b%b want=00", rd_valid, wr_active); end
        n_cmp++; if (err !== 6'd0) begin n_bad++; $display("FAIL reset err got=%b want=000000", err); end
        @(negedge CLK);
        RESET = 1'b0;
        model_reset();
    endtask

    task automatic test_read_basic();
        int r, first, cnt;
        step(1'b0, R_LMR, 2'd0, 12'h032);
        step(1'b0, R_ACT, 2'd1, 12'h155);
        repeat (3) nop();
        step(1'b0, R_RD, 2'd1, 12'h000);
        r = cyc; first = -1; cnt = 0;
        n_cmp++; if (cmd_code !== 3'd2) begin n_bad++; $display("FAIL basic cmd_code got=%0d want=2", cmd_code); end
        for (int i = 0; i < 12; i++) begin
            nop();
            n_cmp++; if (rd_valid !== exp_rd(cyc)) begin n_bad++; $display("FAIL basic rd_valid cyc=%0d got=%b want=%b", cyc - r, rd_valid, exp_rd(cyc)); end
            if (rd_valid === 1'b1) begin
                cnt++;
                if (first < 0) first = cyc - r;
            end
        end
        n_cmp++; if (first != 3) begin n_bad++; $display("FAIL basic rd_start got=%0d want=3", first); end
        n_cmp++; if (cnt != 4) begin n_bad++; $display("FAIL basic rd_beats got=%0d want=4", cnt); end
        n_cmp++; if (burst_len !== 4'd4 || cas_lat !== 2'd3) begin n_bad++; $display("FAIL basic mode got=BL%0d CL%0d want=BL4 CL3", burst_len, cas_lat); end
        n_cmp++; if (bank_open !== 4'b0010) begin n_bad++; $display("FAIL basic bank_open got=%b want=0010", bank_open); end
        n_cmp++; if (open_row[23:12] !== 12'h155) begin n_bad++; $display("FAIL basic open_row1 got=%h want=155", open_row[23:12]); end
        n_cmp++; if (err !== 6'd0) begin n_bad++; $display("FAIL basic err got=%b want=000000", err); end
    endtask

    task automatic test_trcd();
        int cnt;
        cnt = 0;
        step(1'b0, R_ACT, 2'd0, 12'h0AA);
        step(1'b0, R_RD, 2'd0, 12'h000);
        for (int i = 0; i < 12; i++) begin
            nop();
            if (rd_valid === 1'b1) cnt++;
        end
        n_cmp++; if (err !== 6'b000100) begin n_bad++; $display("FAIL trcd err got=%b want=000100", err); end
        n_cmp++; if (cnt != 4) begin n_bad++; $display("FAIL trcd rd_beats got=%0d want=4", cnt); end
    endtask

    task automatic test_act_pre();
        step(1'b0, R_ACT, 2'd2, 12'h111);
        step(1'b0, R_ACT, 2'd2, 12'h222);
        n_cmp++; if (err[0] !== 1'b1) begin n_bad++; $display("FAIL actopen err0 got=%b want=1", err[0]); end
        n_cmp++; if (open_row[35:24] !== 12'h222) begin n_bad++; $display("FAIL actopen row2 got=%h want=222", open_row[35:24]); end
        n_cmp++; if (err[3] !== 1'b0) begin n_bad++; $display("FAIL prepre err3 got=%b want=0", err[3]); end
        step(1'b0, R_PRE, 2'd0, 12'h400);
        n_cmp++; if (bank_open !== 4'b0000) begin n_bad++; $display("FAIL preall bank_open got=%b want=0000", bank_open); end
        step(1'b0, R_ACT, 2'd3, 12'h333);
        n_cmp++; if (err[3] !== 1'b1) begin n_bad++; $display("FAIL trp err3 got=%b want=1", err[3]); end
        n_cmp++; if (bank_open !== 4'b1000) begin n_bad++; $display("FAIL trp bank_open got=%b want=1000", bank_open); end
    endtask

    task automatic test_bst();
        int cnt;
        apply_reset();
        step(1'b0, R_LMR, 2'd0, 12'h023);
        n_cmp++; if (cas_lat !== 2'd2 || burst_len !== 4'd8) begin n_bad++; $display("FAIL bst mode got=CL%0d BL%0d want=CL2 BL8", cas_lat, burst_len); end
        step(1'b0, R_ACT, 2'd0, 12'h0F0);
        repeat (3) nop();
        step(1'b0, R_RD, 2'd0, 12'h000);
        cnt = 0;
        for (int k = 1; k <= 14; k++) begin
            if (k == 3) step(1'b0, R_BST, 2'd0, 12'h000);
            else        nop();
            n_cmp++; if (rd_valid !== exp_rd(cyc)) begin n_bad++; $display("FAIL bst rd_valid k=%0d got=%b want=%b", k, rd_valid, exp_rd(cyc)); end
            if (rd_valid === 1'b1) cnt++;
        end
        n_cmp++; if (cnt != 3) begin n_bad++; $display("FAIL bst rd_beats got=%0d want=3", cnt); end
        step(1'b0, R_WR, 2'd0, 12'h000);
        cnt = (wr_active === 1'b1) ? 1 : 0;
        for (int k = 1; k <= 12; k++) begin
            if (k == 2) step(1'b0, R_BST, 2'd0, 12'h000);
            else        nop();
            n_cmp++; if (wr_active !== exp_wr(cyc)) begin n_bad++; $display("FAIL bst wr_active k=%0d got=%b want=%b", k, wr_active, exp_wr(cyc)); end
            if (wr_active === 1'b1) cnt++;
        end
        n_cmp++; if (cnt != 2) begin n_bad++; $display("FAIL bst wr_beats got=%0d want=2", cnt); end
        n_cmp++; if (err !== 6'd0) begin n_bad++; $display("FAIL bst err got=%b want=000000", err); end
    endtask

    task automatic test_ref();
        apply_reset();
        step(1'b0, R_REF, 2'd0, 12'h000);
        n_cmp++; if (err !== 6'd0) begin n_bad++; $display("FAIL ref_idle err got=%b want=000000", err); end
        nop();
        step(1'b0, R_ACT, 2'd0, 12'h001);
        n_cmp++; if (err !== 6'b010000) begin n_bad++; $display("FAIL trfc err got=%b want=010000", err); end
        apply_reset();
        step(1'b0, R_ACT, 2'd0, 12'h001);
        repeat (3) nop();
        step(1'b0, R_REF, 2'd0, 12'h000);
        n_cmp++; if (err !== 6'b010000) begin n_bad++; $display("FAIL ref_open err got=%b want=010000", err); end
        nop();
        step(1'b0, R_ACT, 2'd1, 12'h002);
        repeat (8) nop();
        step(1'b0, R_LMR, 2'd0, 12'h017);
        n_cmp++; if (err[5] !== 1'b1) begin n_bad++; $display("FAIL lmr_bad err5 got=%b want=1", err[5]); end
        n_cmp++; if (cas_lat !== 2'd2 || burst_len !== 4'd1) begin n_bad++; $display("FAIL lmr_bad mode got=CL%0d BL%0d want=CL2 BL1", cas_lat, burst_len); end
    endtask

    task automatic test_reset_mid();
        logic seen;
        apply_reset();
        step(1'b0, R_LMR, 2'd0, 12'h023);
        step(1'b0, R_ACT, 2'd0, 12'h010);
        repeat (3) nop();
        step(1'b0, R_RD, 2'd0, 12'h000);
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            nop();
            if (rd_valid === 1'b1) seen = 1'b1;
        end
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL midreset no rd_valid got=0 want=1 within 8 cycles"); end
        #2;
        RESET = 1'b1;
        CS_N  = 1'b1;
        #1;
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL midreset rd_valid got=%b want=0", rd_valid); end
        n_cmp++; if (bank_open !== 4'd0 || open_row !== '0) begin n_bad++; $display("FAIL midreset banks got=%b/%h want=0/0", bank_open, open_row); end
        n_cmp++; if (cas_lat !== 2'd2 || burst_len !== 4'd1) begin n_bad++; $display("FAIL midreset mode got=CL%0d BL%0d want=CL2 BL1", cas_lat, burst_len); end
        n_cmp++; if (cmd_code !== 3'd0 || wr_active !== 1'b0 || err !== 6'd0) begin n_bad++; $display("FAIL midreset misc got=%0d/%b/%b want=0/0/0", cmd_code, wr_active, err); end
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        model_reset();
        step(1'b0, R_ACT, 2'd1, 12'h3C3);
        n_cmp++; if (cmd_code !== 3'd1) begin n_bad++; $display("FAIL postreset cmd_code got=%0d want=1", cmd_code); end
        n_cmp++; if (bank_open !== 4'b0010 || open_row[23:12] !== 12'h3C3) begin n_bad++; $display("FAIL postreset bank got=%b/%h want=0010/3c3", bank_open, open_row[23:12]); end
        n_cmp++; if (err !== 6'd0) begin n_bad++; $display("FAIL postreset err got=%b want=000000", err); end
    endtask

    task automatic rand_run(input int n);
        logic [2:0] rcw;
        logic [ROW_W*4-1:0] exp_row;
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 11))
                4, 11:   rcw = R_ACT;
                5, 10:   rcw = R_RD;
                6:       rcw = R_WR;
                7:       rcw = R_BST;
                8:       rcw = R_PRE;
                9:       rcw = R_REF;
                default: rcw = R_NOP;
            endcase
            step(($urandom_range(0, 7) == 0), rcw, 2'($urandom_range(0, 3)), 12'($urandom));
            exp_row = {m_row[3], m_row[2], m_row[1], m_row[0]};
            n_cmp++; if (cmd_code !== 3'(m_code)) begin n_bad++; $display("FAIL rnd cmd_code cyc=%0d got=%0d want=%0d", cyc, cmd_code, m_code); end
            n_cmp++; if (bank_open !== m_open) begin n_bad++; $display("FAIL rnd bank_open cyc=%0d got=%b want=%b", cyc, bank_open, m_open); end
            n_cmp++; if (open_row !== exp_row) begin n_bad++; $display("FAIL rnd open_row cyc=%0d got=%h want=%h", cyc, open_row, exp_row); end
            n_cmp++; if (err !== m_err) begin n_bad++; $display("FAIL rnd err cyc=%0d got=%b want=%b", cyc, err, m_err); end
            n_cmp++; if (rd_valid !== exp_rd(cyc)) begin n_bad++; $display("FAIL rnd rd_valid cyc=%0d got=%b want=%b", cyc, rd_valid, exp_rd(cyc)); end
            n_cmp++; if (wr_active !== exp_wr(cyc)) begin n_bad++; $display("FAIL rnd wr_active cyc=%0d got=%b want=%b", cyc, wr_active, exp_wr(cyc)); end
            n_cmp++; if (cas_lat !== 2'(m_cl) || burst_len !== 4'(m_bl)) begin n_bad++; $display("FAIL rnd mode cyc=%0d got=CL%0d BL%0d want=CL%0d BL%0d", cyc, cas_lat, burst_len, m_cl, m_bl); end
        end
    endtask

    task automatic test_random();
        apply_reset();
        step(1'b0, R_LMR, 2'd0, 12'h023);
        rand_run(400);
        repeat (12) nop();
        step(1'b0, R_PRE, 2'd0, 12'h400);
        repeat (8) nop();
        step(1'b0, R_LMR, 2'd0, 12'h031);
        rand_run(400);
    endtask

    initial begin
        RESET = 1'b1;
        CS_N  = 1'b1;
        RAS_N = 1'b1;
        CAS_N = 1'b1;
        WE_N  = 1'b1;
        BA    = '0;
        SA    = '0;
        cyc   = 0;
        base  = 0;
        for (int k = 0; k < 8192; k++) begin
            h_cmd[k] = 0;
            h_cl[k]  = 2;
            h_bl[k]  = 1;
        end
        model_reset();
        test_reset();
        test_read_basic();
        test_trcd();
        test_act_pre();
        test_bst();
        test_ref();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
